mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port, byte-addressable unified `memory` between instruction fetch (IF, read-only) and load/store (LS, read/write). It sits between the core's fetch and memory stages and the `memory` instance. It serialises accesses with valid/ready handshakes and returns registered read data one cycle after acceptance. It also keeps a saturating contention counter for performance debug.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates IF (read-only) and LS (read/write) requesters onto one single-port memory.
// Define MEM_ARB_RR_EN for round-robin priority; otherwise LS has fixed priority over IF.
module mem_arbiter #(
  parameter int unsigned     AWIDTH    = 32,
  parameter int unsigned     DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 'h01000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_rsp_valid_o,
  input  logic              if_rsp_ready_i,
  output logic [DWIDTH-1:0] if_rsp_data_o,
  input  logic              ls_req_valid_i,
  output logic              ls_req_ready_o,
  input  logic [AWIDTH-1:0] ls_addr_i,
  input  logic              ls_we_i,
  input  logic [DWIDTH-1:0] ls_wdata_i,
  output logic              ls_rsp_valid_o,
  input  logic              ls_rsp_ready_i,
  output logic [DWIDTH-1:0] ls_rsp_data_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic [15:0]       conflict_cnt_o
);

  typedef enum logic [1:0] {StIdle, StRespIf, StRespLs} state_e;

  state_e            state_q;
  logic [DWIDTH-1:0] rsp_data_q;
  logic [15:0]       conflict_cnt_q;

  logic rsp_hs;
  logic can_issue;
  logic ls_first;
  logic grant_ls;
  logic grant_if;

`ifdef MEM_ARB_RR_EN
  // Set when LS won the most recent grant; reset favours LS.
  logic last_ls_q;
  assign ls_first = ~last_ls_q;
`else
  assign ls_first = 1'b1;
`endif

  assign rsp_hs = ((state_q == StRespIf) && if_rsp_ready_i) ||
                  ((state_q == StRespLs) && ls_rsp_ready_i);

  // Gating with rst keeps a store handshaking in the reset cycle from reaching memory.
  assign can_issue = !rst && ((state_q == StIdle) || rsp_hs);
  assign grant_ls  = can_issue && ls_req_valid_i && (ls_first || !if_req_valid_i);
  assign grant_if  = can_issue && if_req_valid_i && !grant_ls;

  assign if_req_ready_o = grant_if;
  assign ls_req_ready_o = grant_ls;

  always_comb begin
    mem_addr_o     = BASE_ADDR;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if (grant_if) begin
      mem_addr_o    = if_addr_i;
      mem_read_en_o = 1'b1;
    end else if (grant_ls) begin
      mem_addr_o = ls_addr_i;
      if (ls_we_i) begin
        mem_data_o     = ls_wdata_i;
        mem_write_en_o = 1'b1;
      end else begin
        mem_read_en_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      rsp_data_q     <= '0;
      conflict_cnt_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_ls_q      <= 1'b0;
`endif
    end else begin
      if (grant_if) begin
        state_q <= StRespIf;
      end else if (grant_ls) begin
        state_q <= StRespLs;
      end else if (rsp_hs) begin
        state_q <= StIdle;
      end

      if (grant_if || (grant_ls && !ls_we_i)) begin
        rsp_data_q <= mem_data_i;
      end else if (grant_ls) begin
        rsp_data_q <= '0;
      end

      if ((grant_if || grant_ls) && if_req_valid_i && ls_req_valid_i &&
          (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end

`ifdef MEM_ARB_RR_EN
      if (grant_if || grant_ls) begin
        last_ls_q <= grant_ls;
      end
`endif
    end
  end

  assign if_rsp_valid_o = (state_q == StRespIf);
  assign ls_rsp_valid_o = (state_q == StRespLs);
  assign if_rsp_data_o  = (state_q == StRespIf) ? rsp_data_q : '0;
  assign ls_rsp_data_o  = (state_q == StRespLs) ? rsp_data_q : '0;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed memory model.
module tb_mem_arbiter;

  localparam logic [31:0] BASE = 32'h01000000;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [31:0] ls_addr;
  logic        ls_we;
  logic [31:0] ls_wdata;
  logic        ls_rsp_valid;
  logic        ls_rsp_ready;
  logic [31:0] ls_rsp_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_rdata;
  logic [15:0] conflict_cnt;

  logic [31:0] mem [0:255];

  int n_asserts = 0;
  int n_fail    = 0;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid_i (if_req_valid),
    .if_req_ready_o (if_req_ready),
    .if_addr_i      (if_addr),
    .if_rsp_valid_o (if_rsp_valid),
    .if_rsp_ready_i (if_rsp_ready),
    .if_rsp_data_o  (if_rsp_data),
    .ls_req_valid_i (ls_req_valid),
    .ls_req_ready_o (ls_req_ready),
    .ls_addr_i      (ls_addr),
    .ls_we_i        (ls_we),
    .ls_wdata_i     (ls_wdata),
    .ls_rsp_valid_o (ls_rsp_valid),
    .ls_rsp_ready_i (ls_rsp_ready),
    .ls_rsp_data_o  (ls_rsp_data),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_wdata),
    .mem_read_en_o  (mem_read_en),
    .mem_write_en_o (mem_write_en),
    .mem_data_i     (mem_rdata),
    .conflict_cnt_o (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  // Only the two preloaded words are (re)initialised on reset; other contents survive.
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 32'h00500093;
      mem[1] <= 32'h11112222;
    end else if (mem_write_en) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ls_order;

  initial begin
`ifdef MEM_ARB_RR_EN
    ls_order = 4'b0101;
`else
    ls_order = 4'b1111;
`endif
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0; if_rsp_ready = 1'b0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_wdata = '0; ls_rsp_ready = 1'b0;

    // Reset: two cycles
    step();
    step();
    chk("rst_if_req_ready", {31'b0, if_req_ready}, 32'd0);
    chk("rst_ls_req_ready", {31'b0, ls_req_ready}, 32'd0);
    chk("rst_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd0);
    chk("rst_ls_rsp_valid", {31'b0, ls_rsp_valid}, 32'd0);
    chk("rst_if_rsp_data", if_rsp_data, 32'd0);
    chk("rst_ls_rsp_data", ls_rsp_data, 32'd0);
    chk("rst_mem_en", {30'b0, mem_read_en, mem_write_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_conflict_cnt", {16'b0, conflict_cnt}, 32'd0);
    rst = 1'b0;

    // IF load alone
    if_req_valid = 1'b1; if_addr = BASE;
    #1;
    chk("if_req_ready", {31'b0, if_req_ready}, 32'd1);
    chk("if_ls_not_ready", {31'b0, ls_req_ready}, 32'd0);
    chk("if_mem_read_en", {31'b0, mem_read_en}, 32'd1);
    chk("if_mem_addr", mem_addr, BASE);
    step();
    chk("if_rsp_valid", {31'b0, if_rsp_valid}, 32'd1);
    chk("if_rsp_data", if_rsp_data, 32'h00500093);

    // Backpressure: new IF request waits while response is not consumed
    if_addr = BASE + 32'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_no_grant", {31'b0, if_req_ready}, 32'd0);
      chk("bp_no_mem_read", {31'b0, mem_read_en}, 32'd0);
      chk("bp_data_held", if_rsp_data, 32'h00500093);
      chk("bp_valid_held", {31'b0, if_rsp_valid}, 32'd1);
      step();
    end
    if_rsp_ready = 1'b1;
    #1;
    chk("bp_grant_on_ready", {31'b0, if_req_ready}, 32'd1);
    step();
    if_req_valid = 1'b0;
    chk("bp_second_rsp", if_rsp_data, 32'h11112222);
    step();
    chk("bp_back_idle", {31'b0, if_rsp_valid}, 32'd0);

    // Store then load to the same address
    ls_req_valid = 1'b1; ls_we = 1'b1; ls_addr = BASE + 32'h10; ls_wdata = 32'hDEADBEEF;
    ls_rsp_ready = 1'b1;
    #1;
    chk("st_ready", {31'b0, ls_req_ready}, 32'd1);
    chk("st_write_en", {30'b0, mem_read_en, mem_write_en}, 32'd1);
    chk("st_mem_data", mem_wdata, 32'hDEADBEEF);
    step();
    ls_we = 1'b0;
    #1;
    chk("st_ack_valid", {31'b0, ls_rsp_valid}, 32'd1);
    chk("st_ack_data", ls_rsp_data, 32'd0);
    chk("ld_back_to_back", {31'b0, ls_req_ready}, 32'd1);
    step();
    ls_req_valid = 1'b0;
    chk("ld_valid", {31'b0, ls_rsp_valid}, 32'd1);
    chk("ld_data", ls_rsp_data, 32'hDEADBEEF);
    step();

    // Reset during RESP_LS with a store handshaking in the reset cycle
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_rsp_ready = 1'b0;
    step();
    chk("rl_resp_pending", {31'b0, ls_rsp_valid}, 32'd1);
    rst = 1'b1; ls_we = 1'b1; ls_wdata = 32'h12345678; ls_rsp_ready = 1'b1;
    #1;
    chk("rl_write_blocked", {31'b0, mem_write_en}, 32'd0);
    chk("rl_no_ready", {31'b0, ls_req_ready}, 32'd0);
    step();
    chk("rl_rsp_dropped", {31'b0, ls_rsp_valid}, 32'd0);
    chk("rl_rsp_data", ls_rsp_data, 32'd0);
    chk("rl_mem_unchanged", mem[4], 32'hDEADBEEF);
    rst = 1'b0; ls_req_valid = 1'b0; ls_we = 1'b0;
    step();

    // Contention: both valid for four grants
    if_req_valid = 1'b1; if_addr = BASE;
    ls_req_valid = 1'b1; ls_addr = BASE + 32'h10; ls_we = 1'b0;
    if_rsp_ready = 1'b1; ls_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ct_ls_grant%0d", i), {31'b0, ls_req_ready}, {31'b0, ls_order[i]});
      chk($sformatf("ct_if_grant%0d", i), {31'b0, if_req_ready}, {31'b0, ~ls_order[i]});
      step();
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    chk("ct_conflict_cnt", {16'b0, conflict_cnt}, 32'd4);
    chk("ct_last_rsp_ls", {31'b0, ls_rsp_valid}, {31'b0, ls_order[3]});
    step();
    chk("ct_cnt_stable", {16'b0, conflict_cnt}, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
